// File: rtl/stream_arbiter.sv
// ---------------------------------------------------------------------------
// stream_arbiter
//
// Merges NSRC byte-wide AXI-Stream sources onto a single output stream.
// Sources are granted one whole packet at a time in round-robin order. When
// HDR_EN is set, each forwarded packet is preceded by a header byte 8'hA0|sel
// that identifies the granted source. If the granted source leaves a gap of
// TIMEOUT cycles inside a packet (TIMEOUT=0 disables this), the packet is
// closed with an 8'hFF/tlast beat, o_abort pulses, and the arbiter moves on.
// The rest of that source's bytes go out later as a new packet.
//
// Ports
//   i_clk     : clock, all state on the rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_tdata   : source data, source k on bits [8k+7:8k]
//   i_tlast   : per-source end of packet
//   i_tvalid  : per-source valid
//   o_tready  : per-source ready (only the granted source, only in PKT)
//   o_tdata   : merged stream data
//   o_tlast   : merged end of packet
//   o_tvalid  : merged valid
//   i_tready  : downstream ready
//   o_abort   : one-cycle pulse when a packet is closed by timeout
// ---------------------------------------------------------------------------
module stream_arbiter #(
  parameter int NSRC    = 4,
  parameter int HDR_EN  = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [8*NSRC-1:0] i_tdata,
  input  logic [NSRC-1:0]   i_tlast,
  input  logic [NSRC-1:0]   i_tvalid,
  output logic [NSRC-1:0]   o_tready,
  output logic [7:0]        o_tdata,
  output logic              o_tlast,
  output logic              o_tvalid,
  input  logic              i_tready,
  output logic              o_abort
);

  localparam int SW = $clog2(NSRC);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PKT, ABORT} state_t;

  state_t        state, state_nxt;
  logic [SW-1:0] sel, sel_nxt;
  logic [SW-1:0] ptr, ptr_nxt;
  logic [SW-1:0] sel_inc;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          abort_nxt;
  logic          armed;

  logic          rr_found;
  logic [SW-1:0] rr_idx;
  logic [SW-1:0] cand_idx;
  int            cand;

  logic [7:0]    sel_data;
  logic          sel_last;
  logic          sel_valid;

  // The arbiter is held in IDLE for the first edge after reset release so the
  // first grant can happen no earlier than the second rising edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      armed <= 1'b0;
    end else begin
      armed <= 1'b1;
    end
  end

  // Round-robin search: the first requesting source at or after ptr,
  // wrapping from NSRC-1 back to 0.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = ptr;
    cand     = 0;
    cand_idx = '0;
    for (int i = 0; i < NSRC; i++) begin
      cand     = (int'(ptr) + i) % NSRC;
      cand_idx = SW'(cand);
      if (!rr_found && i_tvalid[cand_idx]) begin
        rr_found = 1'b1;
        rr_idx   = cand_idx;
      end
    end
  end

  // Granted source's stream, and the pointer value used after its packet ends.
  always_comb begin
    sel_data  = i_tdata[{sel, 3'b000} +: 8];
    sel_last  = i_tlast[sel];
    sel_valid = i_tvalid[sel];
    sel_inc   = (sel == SW'(NSRC - 1)) ? '0 : sel + 1'b1;
  end

  // State, grant, pointer, idle counter and the abort pulse register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      sel     <= '0;
      ptr     <= '0;
      cnt     <= '0;
      o_abort <= 1'b0;
    end else begin
      state   <= state_nxt;
      sel     <= sel_nxt;
      ptr     <= ptr_nxt;
      cnt     <= cnt_nxt;
      o_abort <= abort_nxt;
    end
  end

  // Next-state and output decode. In PKT the output is a straight
  // combinational pass-through of the granted source, so the source's own
  // AXI hold rules keep o_tdata/o_tlast stable under backpressure. The idle
  // counter is zero outside PKT, clears on each accepted beat, and only
  // counts cycles where the source itself has nothing to offer. The abort is
  // taken on the cycle the counter steps onto TIMEOUT.
  always_comb begin
    state_nxt = state;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = '0;
    abort_nxt = 1'b0;
    o_tvalid  = 1'b0;
    o_tdata   = 8'h00;
    o_tlast   = 1'b0;
    o_tready  = '0;

    case (state)
      IDLE: begin
        if (armed && rr_found) begin
          sel_nxt   = rr_idx;
          state_nxt = (HDR_EN != 0) ? HDR : PKT;
        end
      end

      HDR: begin
        o_tvalid = 1'b1;
        o_tdata  = 8'hA0 | 8'(sel);
        if (i_tready) begin
          state_nxt = PKT;
        end
      end

      PKT: begin
        o_tvalid      = sel_valid;
        o_tdata       = sel_data;
        o_tlast       = sel_last;
        o_tready[sel] = i_tready;
        if (sel_valid && i_tready) begin
          cnt_nxt = '0;
          if (sel_last) begin
            ptr_nxt   = sel_inc;
            state_nxt = IDLE;
          end
        end else if (!sel_valid) begin
          if (TIMEOUT > 0) begin
            cnt_nxt = cnt + 1'b1;
            if (int'(cnt) == TIMEOUT - 1) begin
              state_nxt = ABORT;
              abort_nxt = 1'b1;
            end
          end
        end else begin
          cnt_nxt = cnt;
        end
      end

      ABORT: begin
        o_tvalid = 1'b1;
        o_tdata  = 8'hFF;
        o_tlast  = 1'b1;
        if (i_tready) begin
          ptr_nxt   = sel_inc;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_stream_arbiter.sv
// ---------------------------------------------------------------------------
// tb_stream_arbiter
//
// Bench for stream_arbiter. The main instance uses NSRC=4, HDR_EN=1 and
// TIMEOUT=8. A second instance with HDR_EN=0 covers headerless forwarding.
// Each source is a queue of {tlast,tdata} beats. Expected output beats are
// queued when the stimulus is loaded, and are popped and compared as the DUT
// hands them downstream.
// ---------------------------------------------------------------------------
module tb_stream_arbiter;

  localparam int NSRC = 4;
  localparam int TMO  = 8;

  typedef struct packed {
    logic       is_data;
    logic [1:0] src;
    logic       last;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] i_tdata;
  logic [3:0]  i_tlast;
  logic [3:0]  i_tvalid;
  logic [3:0]  o_tready;
  logic [7:0]  o_tdata;
  logic        o_tlast;
  logic        o_tvalid;
  logic        i_tready;
  logic        o_abort;

  logic [31:0] n_tdata;
  logic [3:0]  n_tlast;
  logic [3:0]  n_tvalid;
  logic [3:0]  n_o_tready;
  logic [7:0]  n_o_tdata;
  logic        n_o_tlast;
  logic        n_o_tvalid;
  logic        n_tready;
  logic        n_o_abort;

  int          checks = 0;
  int          passes = 0;
  exp_t        exp_q[$];
  logic [8:0]  src_q[NSRC][$];
  logic [3:0]  hs;
  logic        out_hs;
  logic        rand_ready = 1'b0;

  always #5 clk = ~clk;

  stream_arbiter #(.NSRC(NSRC), .HDR_EN(1), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .o_tready(o_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .i_tready(i_tready),
    .o_abort(o_abort)
  );

  stream_arbiter #(.NSRC(NSRC), .HDR_EN(0), .TIMEOUT(1024)) dut_nohdr (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_tdata(n_tdata), .i_tlast(n_tlast), .i_tvalid(n_tvalid), .o_tready(n_o_tready),
    .o_tdata(n_o_tdata), .o_tlast(n_o_tlast), .o_tvalid(n_o_tvalid), .i_tready(n_tready),
    .o_abort(n_o_abort)
  );

  // Load a packet into a source queue and queue its expected header and data.
  task automatic push_pkt(input int src, input int n, input logic [7:0] base, input logic [7:0] step);
    exp_q.push_back({1'b0, 2'(src), 1'b0, 8'hA0 | 8'(src)});
    for (int i = 0; i < n; i++) begin
      src_q[src].push_back({(i == n - 1), 8'(base + step * i)});
      exp_q.push_back({1'b1, 2'(src), (i == n - 1), 8'(base + step * i)});
    end
  endtask

  task automatic drive_sources();
    logic [8:0] h;
    for (int k = 0; k < NSRC; k++) begin
      if (src_q[k].size() > 0) begin
        h = src_q[k][0];
        i_tvalid[k]       = 1'b1;
        i_tdata[8*k +: 8] = h[7:0];
        i_tlast[k]        = h[8];
      end else begin
        i_tvalid[k]       = 1'b0;
        i_tdata[8*k +: 8] = 8'h00;
        i_tlast[k]        = 1'b0;
      end
    end
  endtask

  // Observe the handshakes that will complete on the coming rising edge.
  task automatic sample();
    @(negedge clk);
    hs     = i_tvalid & o_tready;
    out_hs = o_tvalid & i_tready;
  endtask

  // Complete the cycle: retire accepted source beats and drive the next ones.
  task automatic advance();
    logic [8:0] dummy;
    @(posedge clk);
    #1;
    for (int k = 0; k < NSRC; k++) begin
      if (hs[k] && src_q[k].size() > 0) dummy = src_q[k].pop_front();
    end
    hs = '0;
    drive_sources();
    i_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic test_reset();
    rst_n    = 1'b1;
    i_tdata  = '0; i_tlast = '0; i_tvalid = '0; i_tready = 1'b1;
    n_tdata  = '0; n_tlast = '0; n_tvalid = '0; n_tready = 1'b1;
    hs       = '0;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tvalid, o_tready, o_tdata, o_tlast, o_abort} !== 15'd0)
      $display("[TB] FAIL reset_outputs: got v=%b r=%b d=%h l=%b a=%b want all zero",
               o_tvalid, o_tready, o_tdata, o_tlast, o_abort);
    else passes++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) sample();
    checks++;
    if (o_tvalid !== 1'b0) $display("[TB] FAIL reset_idle: got o_tvalid=%b want 0", o_tvalid);
    else passes++;
  endtask

  task automatic test_round_robin();
    exp_t e; logic [3:0] rdy; int budget = 200;
    for (int r = 0; r < 3; r++)
      for (int k = 0; k < NSRC; k++) push_pkt(k, 2, 8'(16 * k + 2 * r), 8'h01);
    advance();
    while (exp_q.size() > 0 && budget > 0) begin
      sample();
      if (o_tvalid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        rdy = e.is_data ? (4'(i_tready) << e.src) : 4'b0;
        checks++;
        if (o_tready !== rdy) $display("[TB] FAIL rr_ready: got %b want %b", o_tready, rdy);
        else passes++;
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL rr_beat: got unexpected %h want nothing", o_tdata);
        else begin
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== {e.last, e.data})
            $display("[TB] FAIL rr_beat: got %b/%h want %b/%h", o_tlast, o_tdata, e.last, e.data);
          else passes++;
        end
      end
      advance();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL rr_drain: got %0d beats left want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_single_source();
    exp_t e; logic [3:0] rdy; int budget = 40;
    push_pkt(1, 3, 8'h11, 8'h11);
    advance();
    while (exp_q.size() > 0 && budget > 0) begin
      sample();
      if (o_tvalid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        rdy = e.is_data ? (4'(i_tready) << e.src) : 4'b0;
        checks++;
        if (o_tready !== rdy) $display("[TB] FAIL single_ready: got %b want %b", o_tready, rdy);
        else passes++;
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL single_beat: got unexpected %h want nothing", o_tdata);
        else begin
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== {e.last, e.data})
            $display("[TB] FAIL single_beat: got %b/%h want %b/%h", o_tlast, o_tdata, e.last, e.data);
          else passes++;
        end
      end
      advance();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL single_drain: got %0d beats left want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_timeout();
    exp_t e; logic [3:0] rdy; int budget = 120; int aborts = 0; int gap = 0;
    bit seen_first = 0; bit reloaded = 0;
    src_q[0].push_back({1'b0, 8'h77});
    exp_q.push_back({1'b0, 2'd0, 1'b0, 8'hA0});
    exp_q.push_back({1'b1, 2'd0, 1'b0, 8'h77});
    exp_q.push_back({1'b0, 2'd0, 1'b1, 8'hFF});
    advance();
    while ((exp_q.size() > 0 || !reloaded) && budget > 0) begin
      sample();
      if (o_abort) begin
        aborts++;
        checks++;
        if (gap != TMO) $display("[TB] FAIL timeout_gap: got %0d idle cycles want %0d", gap, TMO);
        else passes++;
      end
      if (seen_first && aborts == 0 && !o_tvalid) gap++;
      if (o_tvalid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        rdy = e.is_data ? (4'(i_tready) << e.src) : 4'b0;
        checks++;
        if (o_tready !== rdy) $display("[TB] FAIL timeout_ready: got %b want %b", o_tready, rdy);
        else passes++;
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL timeout_beat: got unexpected %h want nothing", o_tdata);
        else begin
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== {e.last, e.data})
            $display("[TB] FAIL timeout_beat: got %b/%h want %b/%h", o_tlast, o_tdata, e.last, e.data);
          else passes++;
          if (e.is_data && e.data == 8'h77) seen_first = 1;
          if (!e.is_data && e.last && !reloaded) begin
            reloaded = 1;
            push_pkt(0, 2, 8'h88, 8'h11);
          end
        end
      end
      advance();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0 || !reloaded)
      $display("[TB] FAIL timeout_drain: got %0d beats left want 0", exp_q.size());
    else passes++;
    checks++;
    if (aborts != 1) $display("[TB] FAIL abort_pulse: got %0d pulse cycles want 1", aborts);
    else passes++;
  endtask

  task automatic test_backpressure();
    exp_t e; logic [3:0] rdy; int budget = 300;
    logic prev_stall = 0; logic [7:0] prev_data = 0; logic prev_last = 0;
    rand_ready = 1'b1;
    push_pkt(2, 12, 8'h40, 8'h03);
    advance();
    while (exp_q.size() > 0 && budget > 0) begin
      sample();
      if (prev_stall) begin
        checks++;
        if (!o_tvalid || o_tdata !== prev_data || o_tlast !== prev_last)
          $display("[TB] FAIL bp_hold: got v=%b %b/%h want v=1 %b/%h",
                   o_tvalid, o_tlast, o_tdata, prev_last, prev_data);
        else passes++;
      end
      prev_stall = o_tvalid && !i_tready;
      prev_data  = o_tdata;
      prev_last  = o_tlast;
      if (o_tvalid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        rdy = e.is_data ? (4'(i_tready) << e.src) : 4'b0;
        checks++;
        if (o_tready !== rdy) $display("[TB] FAIL bp_ready: got %b want %b", o_tready, rdy);
        else passes++;
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL bp_beat: got unexpected %h want nothing", o_tdata);
        else begin
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== {e.last, e.data})
            $display("[TB] FAIL bp_beat: got %b/%h want %b/%h", o_tlast, o_tdata, e.last, e.data);
          else passes++;
        end
      end
      advance();
      budget--;
    end
    rand_ready = 1'b0;
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL bp_drain: got %0d beats left want 0", exp_q.size());
    else passes++;
    advance();
  endtask

  task automatic test_reset_mid_packet();
    exp_t e; logic [3:0] rdy; int budget = 30; int beats = 0;
    push_pkt(3, 8, 8'hC0, 8'h01);
    advance();
    while (beats < 2 && budget > 0) begin
      sample();
      if (out_hs && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({o_tlast, o_tdata} !== {e.last, e.data})
          $display("[TB] FAIL midrst_beat: got %b/%h want %b/%h", o_tlast, o_tdata, e.last, e.data);
        else passes++;
        if (e.is_data) beats++;
      end
      advance();
      budget--;
    end
    checks++;
    if (o_tvalid !== 1'b1 || o_tready !== 4'b1000)
      $display("[TB] FAIL midrst_inflight: got v=%b r=%b want v=1 r=1000", o_tvalid, o_tready);
    else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({o_tvalid, o_tready, o_tdata, o_tlast, o_abort} !== 15'd0)
      $display("[TB] FAIL midrst_outputs: got v=%b r=%b d=%h l=%b a=%b want all zero",
               o_tvalid, o_tready, o_tdata, o_tlast, o_abort);
    else passes++;
    exp_q.delete();
    for (int k = 0; k < NSRC; k++) src_q[k].delete();
    hs = '0;
    push_pkt(1, 2, 8'h51, 8'h01);
    push_pkt(3, 2, 8'h53, 8'h01);
    advance();
    @(negedge clk);
    rst_n = 1'b1;
    advance();
    sample();
    checks++;
    if (o_tvalid !== 1'b0) $display("[TB] FAIL early_start: got o_tvalid=%b after first edge want 0", o_tvalid);
    else passes++;
    advance();
    budget = 40;
    while (exp_q.size() > 0 && budget > 0) begin
      sample();
      if (o_tvalid) begin
        e = (exp_q.size() > 0) ? exp_q[0] : '0;
        rdy = e.is_data ? (4'(i_tready) << e.src) : 4'b0;
        checks++;
        if (o_tready !== rdy) $display("[TB] FAIL midrst_ready: got %b want %b", o_tready, rdy);
        else passes++;
      end
      if (out_hs) begin
        checks++;
        if (exp_q.size() == 0) $display("[TB] FAIL midrst_grant: got unexpected %h want nothing", o_tdata);
        else begin
          e = exp_q.pop_front();
          if ({o_tlast, o_tdata} !== {e.last, e.data})
            $display("[TB] FAIL midrst_grant: got %b/%h want %b/%h", o_tlast, o_tdata, e.last, e.data);
          else passes++;
        end
      end
      advance();
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) $display("[TB] FAIL midrst_drain: got %0d beats left want 0", exp_q.size());
    else passes++;
  endtask

  task automatic test_no_header();
    logic [7:0] nq[$]; logic [7:0] want; int beats = 0; logic hs_n;
    @(posedge clk);
    #1;
    n_tvalid = 4'b0100;
    n_tlast  = 4'b0100;
    n_tdata  = 32'h005A_0000;
    nq.push_back(8'h5A);
    for (int c = 0; c < 12; c++) begin
      hs_n = 1'b0;
      @(negedge clk);
      if (n_o_tvalid) begin
        beats++;
        checks++;
        if (nq.size() == 0) $display("[TB] FAIL nohdr_beat: got unexpected %h want nothing", n_o_tdata);
        else begin
          want = nq.pop_front();
          if ({n_o_tlast, n_o_tdata} !== {1'b1, want})
            $display("[TB] FAIL nohdr_beat: got %b/%h want 1/%h", n_o_tlast, n_o_tdata, want);
          else passes++;
        end
        checks++;
        if (n_o_tready !== 4'b0100) $display("[TB] FAIL nohdr_ready: got %b want 0100", n_o_tready);
        else passes++;
        hs_n = n_o_tready[2] & n_tvalid[2];
      end
      @(posedge clk);
      #1;
      if (hs_n) begin
        n_tvalid = '0;
        n_tlast  = '0;
        n_tdata  = '0;
      end
    end
    checks++;
    if (beats != 1) $display("[TB] FAIL nohdr_count: got %0d beats want 1", beats);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_timeout();
    test_backpressure();
    test_reset_mid_packet();
    test_no_header();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got simulation still running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
